mem_port_sequencer: RTL and testbench
=====================================

MEM_PORT_SEQUENCER -- requirements
Module: mem_port_sequencer

Interface
REQ-001 SHALL have parameter D_WIDTH, default `D_WIDTH from param.v (32), data/address width.
REQ-002 SHALL have parameter WA_WIDTH, default 4, register write-address width.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 i_RegWrite1M, i_MemtoReg1M, i_MemWrite1M  in  1 each  slot-1 M-stage controls.
REQ-006 i_ALUResult1M, i_WriteData1M  in  D_WIDTH each  slot-1 address/ALU result, store data.
REQ-007 i_WA1M  in  WA_WIDTH  slot-1 destination register.
REQ-008 i_RegWrite2M, i_MemtoReg2M, i_MemWrite2M, i_ALUResult2M, i_WriteData2M, i_WA2M  in  as slot 1  slot-2 M-stage fields.
REQ-009 o_dm_en, o_dm_we  out  1 each  data-memory access enable, write enable.
REQ-010 o_dm_addr, o_dm_wdata  out  D_WIDTH each  data-memory address, write data.
REQ-011 i_dm_rdata  in  D_WIDTH  combinational read data for current o_dm_addr.
REQ-012 o_stall  out  1  hold F/D/E stages and EX/MEM register this cycle.
REQ-013 o_RegWrite1W, o_Result1W, o_WA1W  out  1/D_WIDTH/WA_WIDTH  slot-1 WB-stage register.
REQ-014 o_RegWrite2W, o_Result2W, o_WA2W  out  1/D_WIDTH/WA_WIDTH  slot-2 WB-stage register.

Function
REQ-015 memory op for slot n: MemtoRegnM | MemWritenM; single memory port.
REQ-016 FSM states: ISSUE (reset state), SECOND.
REQ-017 ISSUE, both slots memory ops: o_stall=1; port driven by slot 1; i_dm_rdata captured into hold register; WB registers load bubble (both RegWrite W = 0); next SECOND.
REQ-018 ISSUE, at most one memory op: o_stall=0; port driven by that slot (o_dm_en=0 if none); both WB registers load; stay ISSUE.
REQ-019 SECOND: o_stall=0; port driven by slot 2; WB slot 1 Result = hold register if MemtoReg1M else ALUResult1M; WB slot 2 Result = i_dm_rdata if MemtoReg2M else ALUResult2M; next ISSUE.
REQ-020 WB load (non-bubble): RegWritenW<=RegWritenM, WAnW<=WAnM, ResultnW <= read data if MemtoRegnM else ALUResultnM.
REQ-021 o_dm_we = MemWrite of driving slot; o_dm_addr = its ALUResult; o_dm_wdata = its WriteData; o_stall, o_dm_* combinational from state and inputs.
REQ-022 upstream SHALL hold M inputs stable while o_stall=1; block relies on this, no input capture besides hold register.
REQ-023 store slot 1 then load slot 2 same address: load returns slot-1 store data (program order).
REQ-024 both slots store same address: slot-2 data is final memory content.
REQ-025 both slots RegWrite same WA: both forwarded unchanged; WB stage resolves slot 2 as younger.
REQ-026 single-memory-op pairs: 1 cycle; dual-memory-op pairs: 2 cycles, exactly one stall cycle.

Reset
REQ-027 rst asserted: state=ISSUE, hold register=0, all W outputs=0, effective immediately (async).
REQ-028 rst mid-SECOND: aborts slot-2 access; o_stall=0 and o_dm_en follows ISSUE decode of current inputs.

Configuration
REQ-029 macro MEM_STALL_CNT_EN defined: extra output o_stall_cnt (16 bits), counts cycles with o_stall=1, saturates at 16'hFFFF, reset to 0.
REQ-030 MEM_STALL_CNT_EN undefined: no port, no counter logic; all other behaviour identical.

Structure
REQ-031 D_WIDTH, WA_WIDTH default, FSM state encodings SHALL live in param.v.
REQ-032 WB register SHALL be sub-module mem_wb_reg (async active-high reset, load/bubble inputs); FSM, port mux, hold register in top.

Verification
REQ-033 slot1 load addr 0x10 (mem=0xAA), slot2 ALU 0x5 -> no stall; next cycle Result1W=0xAA, Result2W=0x5.
REQ-034 slot1 load 0x10 (0x11), slot2 load 0x14 (0x22) -> stall 1 cycle, RegWrite W=0 then Result1W=0x11, Result2W=0x22.
REQ-035 slot1 store 0x55 to 0x20, slot2 load 0x20 -> Result2W=0x55, one stall.
REQ-036 both store 0x30 (0x1, 0x2) -> memory[0x30]=0x2.
REQ-037 rst pulsed during SECOND -> state ISSUE, W outputs 0, o_stall=0 in reset cycle.
REQ-038 MEM_STALL_CNT_EN: 3 dual-memory pairs -> o_stall_cnt=3; preload near-max count -> saturates at 0xFFFF.

Source files
------------

// File: rtl/mem_port_sequencer_pkg.sv
// Shared types and defaults for the dual-slot memory port sequencer.
// Holds width defaults, FSM encodings and the memory-op decode helper.
package mem_port_sequencer_pkg;

    localparam int D_WIDTH_DEF  = 32;
    localparam int WA_WIDTH_DEF = 4;

    typedef enum logic {
        ST_ISSUE  = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    function automatic logic is_mem_op(input logic memtoreg, input logic memwrite);
        return memtoreg | memwrite;
    endfunction

endpackage

// File: rtl/mem_port_sequencer_wb_reg.sv
// Dual-slot MEM/WB pipeline register with bubble insertion.
// Bubble clears both RegWrite bits; load captures both slots.
module mem_wb_reg #(
    parameter int D_WIDTH  = 32,
    parameter int WA_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                bubble_i,
    input  logic                regwrite1_i,
    input  logic [D_WIDTH-1:0]  result1_i,
    input  logic [WA_WIDTH-1:0] wa1_i,
    input  logic                regwrite2_i,
    input  logic [D_WIDTH-1:0]  result2_i,
    input  logic [WA_WIDTH-1:0] wa2_i,
    output logic                regwrite1_o,
    output logic [D_WIDTH-1:0]  result1_o,
    output logic [WA_WIDTH-1:0] wa1_o,
    output logic                regwrite2_o,
    output logic [D_WIDTH-1:0]  result2_o,
    output logic [WA_WIDTH-1:0] wa2_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite1_o <= 1'b0;
            result1_o   <= '0;
            wa1_o       <= '0;
            regwrite2_o <= 1'b0;
            result2_o   <= '0;
            wa2_o       <= '0;
        end else if (bubble_i) begin
            regwrite1_o <= 1'b0;
            regwrite2_o <= 1'b0;
        end else if (load_i) begin
            regwrite1_o <= regwrite1_i;
            result1_o   <= result1_i;
            wa1_o       <= wa1_i;
            regwrite2_o <= regwrite2_i;
            result2_o   <= result2_i;
            wa2_o       <= wa2_i;
        end
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// Serialises two M-stage slots onto one data-memory port (1 stall when both access).
// Optional MEM_STALL_CNT_EN adds a saturating 16-bit stall-cycle counter output.
module mem_port_sequencer
    import mem_port_sequencer_pkg::*;
#(
    parameter int D_WIDTH  = D_WIDTH_DEF,
    parameter int WA_WIDTH = WA_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_RegWrite1M,
    input  logic                i_MemtoReg1M,
    input  logic                i_MemWrite1M,
    input  logic [D_WIDTH-1:0]  i_ALUResult1M,
    input  logic [D_WIDTH-1:0]  i_WriteData1M,
    input  logic [WA_WIDTH-1:0] i_WA1M,
    input  logic                i_RegWrite2M,
    input  logic                i_MemtoReg2M,
    input  logic                i_MemWrite2M,
    input  logic [D_WIDTH-1:0]  i_ALUResult2M,
    input  logic [D_WIDTH-1:0]  i_WriteData2M,
    input  logic [WA_WIDTH-1:0] i_WA2M,
    output logic                o_dm_en,
    output logic                o_dm_we,
    output logic [D_WIDTH-1:0]  o_dm_addr,
    output logic [D_WIDTH-1:0]  o_dm_wdata,
    input  logic [D_WIDTH-1:0]  i_dm_rdata,
    output logic                o_stall,
    output logic                o_RegWrite1W,
    output logic [D_WIDTH-1:0]  o_Result1W,
    output logic [WA_WIDTH-1:0] o_WA1W,
    output logic                o_RegWrite2W,
    output logic [D_WIDTH-1:0]  o_Result2W,
    output logic [WA_WIDTH-1:0] o_WA2W
`ifdef MEM_STALL_CNT_EN
    ,output logic [15:0]        o_stall_cnt
`endif
);

    state_e               state_q, state_d;
    logic [D_WIDTH-1:0]   hold_q, hold_d;
    logic                 mem1, mem2, dual;
    logic                 sel2, dm_en, stall, bubble;
    logic [D_WIDTH-1:0]   res1, res2;

    assign mem1 = is_mem_op(i_MemtoReg1M, i_MemWrite1M);
    assign mem2 = is_mem_op(i_MemtoReg2M, i_MemWrite2M);
    assign dual = mem1 & mem2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ISSUE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = ST_ISSUE;
        unique case (state_q)
            ST_ISSUE:  state_d = dual ? ST_SECOND : ST_ISSUE;
            ST_SECOND: state_d = ST_ISSUE;
            default:   state_d = ST_ISSUE;
        endcase
    end

    // Stall is masked during reset so an aborted pair never holds upstream.
    always_comb begin
        sel2   = 1'b0;
        dm_en  = 1'b0;
        stall  = 1'b0;
        bubble = 1'b0;
        hold_d = hold_q;
        res1   = i_MemtoReg1M ? i_dm_rdata : i_ALUResult1M;
        res2   = i_MemtoReg2M ? i_dm_rdata : i_ALUResult2M;
        unique case (state_q)
            ST_ISSUE: begin
                if (dual) begin
                    dm_en  = 1'b1;
                    stall  = ~rst;
                    bubble = 1'b1;
                    hold_d = i_dm_rdata;
                end else if (mem1) begin
                    dm_en = 1'b1;
                end else if (mem2) begin
                    dm_en = 1'b1;
                    sel2  = 1'b1;
                end
            end
            ST_SECOND: begin
                dm_en = 1'b1;
                sel2  = 1'b1;
                res1  = i_MemtoReg1M ? hold_q : i_ALUResult1M;
            end
            default: ;
        endcase
    end

    assign o_stall    = stall;
    assign o_dm_en    = dm_en;
    assign o_dm_we    = dm_en & (sel2 ? i_MemWrite2M : i_MemWrite1M);
    assign o_dm_addr  = sel2 ? i_ALUResult2M : i_ALUResult1M;
    assign o_dm_wdata = sel2 ? i_WriteData2M : i_WriteData1M;

    mem_wb_reg #(
        .D_WIDTH  (D_WIDTH),
        .WA_WIDTH (WA_WIDTH)
    ) u_wb (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b1),
        .bubble_i    (bubble),
        .regwrite1_i (i_RegWrite1M),
        .result1_i   (res1),
        .wa1_i       (i_WA1M),
        .regwrite2_i (i_RegWrite2M),
        .result2_i   (res2),
        .wa2_i       (i_WA2M),
        .regwrite1_o (o_RegWrite1W),
        .result1_o   (o_Result1W),
        .wa1_o       (o_WA1W),
        .regwrite2_o (o_RegWrite2W),
        .result2_o   (o_Result2W),
        .wa2_o       (o_WA2W)
    );

`ifdef MEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Scoreboard bench for mem_port_sequencer: directed slot pairs, memory model,
// monitor compares WB registers after every loading clock edge.
module tb_mem_port_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rw1, m2r1, mw1, rw2, m2r2, mw2;
    logic [31:0] alu1, wd1, alu2, wd2;
    logic [3:0]  wa1, wa2;
    logic        dm_en, dm_we, stall;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        rw1w, rw2w;
    logic [31:0] res1w, res2w;
    logic [3:0]  wa1w, wa2w;
`ifdef MEM_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [31:0] mem [0:255];

    typedef struct {
        bit          bubble;
        logic        rw1;
        logic [31:0] r1;
        logic [3:0]  wa1;
        logic        rw2;
        logic [31:0] r2;
        logic [3:0]  wa2;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .i_RegWrite1M  (rw1),
        .i_MemtoReg1M  (m2r1),
        .i_MemWrite1M  (mw1),
        .i_ALUResult1M (alu1),
        .i_WriteData1M (wd1),
        .i_WA1M        (wa1),
        .i_RegWrite2M  (rw2),
        .i_MemtoReg2M  (m2r2),
        .i_MemWrite2M  (mw2),
        .i_ALUResult2M (alu2),
        .i_WriteData2M (wd2),
        .i_WA2M        (wa2),
        .o_dm_en       (dm_en),
        .o_dm_we       (dm_we),
        .o_dm_addr     (dm_addr),
        .o_dm_wdata    (dm_wdata),
        .i_dm_rdata    (dm_rdata),
        .o_stall       (stall),
        .o_RegWrite1W  (rw1w),
        .o_Result1W    (res1w),
        .o_WA1W        (wa1w),
        .o_RegWrite2W  (rw2w),
        .o_Result2W    (res2w),
        .o_WA2W        (wa2w)
`ifdef MEM_STALL_CNT_EN
        ,.o_stall_cnt  (stall_cnt)
`endif
    );

    assign dm_rdata = mem[dm_addr[7:0]];

    always @(posedge clk) begin
        if (!rst && dm_en && dm_we) mem[dm_addr[7:0]] <= dm_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wb_rw1", {31'd0, rw1w}, {31'd0, e.rw1});
            chk("wb_rw2", {31'd0, rw2w}, {31'd0, e.rw2});
            if (!e.bubble) begin
                chk("wb_res1", res1w, e.r1);
                chk("wb_wa1", {28'd0, wa1w}, {28'd0, e.wa1});
                chk("wb_res2", res2w, e.r2);
                chk("wb_wa2", {28'd0, wa2w}, {28'd0, e.wa2});
            end
        end
    end

    task automatic set_slots(
        input logic s1rw, input logic s1m2r, input logic s1mw,
        input logic [31:0] s1alu, input logic [31:0] s1wd, input logic [3:0] s1wa,
        input logic s2rw, input logic s2m2r, input logic s2mw,
        input logic [31:0] s2alu, input logic [31:0] s2wd, input logic [3:0] s2wa);
        rw1 = s1rw; m2r1 = s1m2r; mw1 = s1mw; alu1 = s1alu; wd1 = s1wd; wa1 = s1wa;
        rw2 = s2rw; m2r2 = s2m2r; mw2 = s2mw; alu2 = s2alu; wd2 = s2wd; wa2 = s2wa;
    endtask

    // Called at a negedge with slots already set; returns at the following negedge.
    task automatic run_pair(input string name, input bit dual, input logic en_exp,
                            input logic [31:0] addr_exp, input exp_t e);
        exp_t b;
        #1;
        chk({name, "_stall0"}, {31'd0, stall}, {31'd0, dual});
        chk({name, "_en0"}, {31'd0, dm_en}, {31'd0, en_exp});
        if (en_exp) chk({name, "_addr0"}, dm_addr, addr_exp);
        if (dual) begin
            b = '{bubble: 1'b1, rw1: 1'b0, r1: 32'd0, wa1: 4'd0,
                  rw2: 1'b0, r2: 32'd0, wa2: 4'd0};
            exp_q.push_back(b);
            @(negedge clk);
            #1;
            chk({name, "_stall1"}, {31'd0, stall}, 32'd0);
            chk({name, "_en1"}, {31'd0, dm_en}, 32'd1);
            chk({name, "_addr1"}, dm_addr, alu2);
        end
        e.bubble = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        rst = 1'b1;
        set_slots(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rw1", {31'd0, rw1w}, 32'd0);
        chk("rst_res2", res2w, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        mem[8'h10] = 32'hAA;
        set_slots(1, 1, 0, 32'h10, 0, 4'd3, 1, 0, 0, 32'h5, 0, 4'd4);
        run_pair("ld_alu", 0, 1, 32'h10,
                 '{0, 1'b1, 32'hAA, 4'd3, 1'b1, 32'h5, 4'd4});

        mem[8'h10] = 32'h11;
        mem[8'h14] = 32'h22;
        set_slots(1, 1, 0, 32'h10, 0, 4'd5, 1, 1, 0, 32'h14, 0, 4'd6);
        run_pair("ld_ld", 1, 1, 32'h10,
                 '{0, 1'b1, 32'h11, 4'd5, 1'b1, 32'h22, 4'd6});

        set_slots(0, 0, 1, 32'h20, 32'h55, 4'd1, 1, 1, 0, 32'h20, 0, 4'd7);
        run_pair("st_ld", 1, 1, 32'h20,
                 '{0, 1'b0, 32'h20, 4'd1, 1'b1, 32'h55, 4'd7});

        set_slots(0, 0, 1, 32'h30, 32'h1, 4'd2, 0, 0, 1, 32'h30, 32'h2, 4'd3);
        run_pair("st_st", 1, 1, 32'h30,
                 '{0, 1'b0, 32'h30, 4'd2, 1'b0, 32'h30, 4'd3});
        chk("mem30", mem[8'h30], 32'h2);

        set_slots(1, 0, 0, 32'h100, 0, 4'd9, 1, 0, 0, 32'h200, 0, 4'd9);
        run_pair("alu_alu", 0, 0, 32'h0,
                 '{0, 1'b1, 32'h100, 4'd9, 1'b1, 32'h200, 4'd9});

        set_slots(1, 0, 0, 32'h7, 0, 4'd1, 1, 1, 0, 32'h14, 0, 4'd8);
        run_pair("alu_ld", 0, 1, 32'h14,
                 '{0, 1'b1, 32'h7, 4'd1, 1'b1, 32'h22, 4'd8});

        // Reset during SECOND aborts the slot-2 access.
        set_slots(1, 1, 0, 32'h10, 0, 4'd5, 1, 1, 0, 32'h14, 0, 4'd6);
        exp_q.push_back('{1'b1, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0});
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstS_stall", {31'd0, stall}, 32'd0);
        chk("rstS_en", {31'd0, dm_en}, 32'd1);
        chk("rstS_addr", dm_addr, 32'h10);
        chk("rstS_res1", res1w, 32'd0);
        chk("rstS_wa2", {28'd0, wa2w}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        set_slots(1, 1, 0, 32'h10, 0, 4'd2, 0, 0, 0, 32'h3, 0, 4'd0);
        run_pair("post_rst", 0, 1, 32'h10,
                 '{0, 1'b1, 32'h11, 4'd2, 1'b0, 32'h3, 4'd0});

`ifdef MEM_STALL_CNT_EN
        chk("cnt_after_rst", {16'd0, stall_cnt}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            set_slots(1, 1, 0, 32'h10, 0, 4'd5, 1, 1, 0, 32'h14, 0, 4'd6);
            run_pair("cnt_dual", 1, 1, 32'h10,
                     '{0, 1'b1, 32'h11, 4'd5, 1'b1, 32'h22, 4'd6});
        end
        chk("cnt3", {16'd0, stall_cnt}, 32'd3);
        dut.stall_cnt_q = 16'hFFFD;
        for (int k = 0; k < 3; k++) begin
            set_slots(1, 1, 0, 32'h10, 0, 4'd5, 1, 1, 0, 32'h14, 0, 4'd6);
            run_pair("sat_dual", 1, 1, 32'h10,
                     '{0, 1'b1, 32'h11, 4'd5, 1'b1, 32'h22, 4'd6});
        end
        chk("cnt_sat", {16'd0, stall_cnt}, 32'hFFFF);
`endif

        set_slots(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
